adder_bist: RTL and testbench
=============================

# adder_bist

Built-in self-test sequencer for the N-bit ripple carry adder. It drives every {a, b, c_in} combination into the adder under test. After a fixed settle interval it compares the adder's {c_out, sum} with the golden value a+b+c_in, counting mismatches and latching the first failing vector. It sits beside the adder in lab hardware and replaces hand-stepped stimulus with a synthesizable, self-checking sweep.

## Interface
- WIDTH, 4, operand width of the adder under test (1..8)
- SETTLE, 2, cycles each vector is held before comparison (≥1)
- clk  input  1  system clock, rising-edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin a sweep; sampled only in IDLE or DONE
- dut_a  output  WIDTH  operand a to the adder
- dut_b  output  WIDTH  operand b to the adder
- dut_cin  output  1  carry-in to the adder
- dut_sum  input  WIDTH  sum returned by the adder
- dut_cout  input  1  carry-out returned by the adder
- busy  output  1  high while a sweep is in progress
- done  output  1  high from sweep completion until the next accepted start or reset
- pass  output  1  valid while done; 1 iff err_count == 0
- err_count  output  16  mismatch count, saturating at 16'hFFFF
- fail_valid  output  1  a mismatch has been latched this sweep
- first_fail_vec  output  2*WIDTH+1  {a, b, cin} of the first mismatch

## Operation
- Vector register vec, 2*WIDTH+1 bits: dut_a = vec[2W:W+1], dut_b = vec[W:1], dut_cin = vec[0]. The DUT outputs are driven straight from registers, so there is no combinational path from start.
- Golden value: exp = {1'b0,a} + {1'b0,b} + cin, WIDTH+1 bits. A mismatch is exp != {dut_cout, dut_sum}.
- FSM states: IDLE, SETTLE, CHECK, DONE.
  - IDLE: on start=1, clear vec, err_count, fail_valid and first_fail_vec; load the settle counter with SETTLE-1; go to SETTLE.
  - SETTLE: decrement the counter. When it is 0, go to CHECK.
  - CHECK: compare. On a mismatch, increment err_count (saturating). If fail_valid==0, set it and latch vec into first_fail_vec.
    - If vec is all-ones, go to DONE.
    - Otherwise increment vec, reload the counter, and go to SETTLE.
  - DONE: hold all results. On start=1, behave exactly as start in IDLE.
- busy=1 in SETTLE and CHECK. done=1 in DONE only. pass = done & (err_count==0).
- Vector order is ascending binary from 0 to 2^(2W+1)-1, with no wrap-around beyond all-ones.
- start is ignored while busy. A start held high across DONE restarts the sweep immediately.

## Timing
- Reset, asynchronous, any state: state=IDLE and every output goes to 0. This covers dut_a, dut_b, dut_cin, busy, done, pass, err_count, fail_valid and first_fail_vec. Reset in the middle of a sweep discards all partial results.
- Start accepted at edge k: busy=1 and vec=0 visible after edge k.
- Each vector is presented for SETTLE+1 cycles. The compare samples the DUT outputs at the end of the CHECK cycle, which is SETTLE+1 cycles after the vector was applied.
- Sweep length: 2^(2W+1)·(SETTLE+1) cycles from start-accept to done=1. For W=4 and SETTLE=2 this is 1536 cycles.
- done and busy never overlap. done rises in the same cycle busy falls.
- The final CHECK's error update is visible in the same cycle as done=1.
- Error counter saturation: a mismatch at 16'hFFFF leaves the count unchanged. This is unreachable for WIDTH ≤ 7 and is covered by a formal assertion.

## Test plan
- Correct 4-bit ripple carry adder, SETTLE=2, start pulse → busy for 1536 cycles, then done=1, pass=1, err_count=0, fail_valid=0.
- DUT sum[0] forced 0 → err_count=256, fail_valid=1, first_fail_vec=9'h001 (a=0, b=0, cin=1), pass=0.
- DUT c_out forced 0 → err_count=256, first_fail_vec=9'h01F (a=0, b=15, cin=1).
- rst asserted at cycle 700 of a sweep, then a new start → all outputs 0 during reset. The new sweep runs a full 1536 cycles with err_count counted from 0.
- Tests on start handling:
  - start pulsed at cycles 10 and 900 of a sweep → both are ignored, and done still arrives at 1536.
  - start in DONE with a faulty DUT swapped for a correct one → results clear, and the run ends with pass=1.
- Every cycle, check that dut_a/dut_b/dut_cin are stable across each SETTLE+CHECK window and increment by exactly one vector per window.

Source files
------------

// File: rtl/adder_bist_if.sv
// adder_bist_if: operand/result bus between the BIST sequencer and the adder under test.
interface adder_bist_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0] dut_a, dut_b, dut_sum;
  logic dut_cin, dut_cout;
  modport master(output dut_a, dut_b, dut_cin, input dut_sum, dut_cout);
  modport slave(input dut_a, dut_b, dut_cin, output dut_sum, dut_cout);
endinterface

// File: rtl/adder_bist.sv
// adder_bist: sweeps every {a, b, cin} through an adder, counts mismatches, latches the first failing vector.
module adder_bist #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  adder_bist_if.master         bus,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [15:0]          err_count,
  output logic                 fail_valid,
  output logic [2*WIDTH:0]     first_fail_vec
);
  localparam int VW = 2*WIDTH+1;
  localparam int EW = WIDTH+1;
  localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;
  state_t        state_q;
  logic [VW-1:0] vec_q, ffv_q;
  logic [CW-1:0] cnt_q;
  logic [15:0]   err_q, err_d;
  logic          fv_q, busy_q, done_q, pass_q;
  logic [EW-1:0] exp_w;
  logic          mism, last;
  always_comb begin
    exp_w = {1'b0, vec_q[VW-1:WIDTH+1]} + {1'b0, vec_q[WIDTH:1]} + EW'(vec_q[0]);
    mism  = exp_w != {bus.dut_cout, bus.dut_sum};
    err_d = (mism && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
    last  = &vec_q;
  end
  assign bus.dut_a      = vec_q[VW-1:WIDTH+1];
  assign bus.dut_b      = vec_q[WIDTH:1];
  assign bus.dut_cin    = vec_q[0];
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign fail_valid     = fv_q;
  assign first_fail_vec = ffv_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      ffv_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: if (start) begin
          state_q <= S_SETTLE;
          vec_q   <= '0;
          ffv_q   <= '0;
          err_q   <= '0;
          fv_q    <= 1'b0;
          cnt_q   <= CW'(SETTLE-1);
          busy_q  <= 1'b1;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
        end
        S_SETTLE: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) state_q <= S_CHECK;
        end
        S_CHECK: begin
          err_q <= err_d;
          if (mism && !fv_q) begin
            fv_q  <= 1'b1;
            ffv_q <= vec_q;
          end
          // pass uses the post-update count so the last vector's verdict is included
          if (last) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= err_d == 16'd0;
          end else begin
            vec_q   <= vec_q + 1'b1;
            cnt_q   <= CW'(SETTLE-1);
            state_q <= S_SETTLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  sat_hold: assert property (@(posedge clk) disable iff (rst)
    (state_q == S_CHECK && err_q == 16'hFFFF) |=> err_q == 16'hFFFF);
endmodule

// File: tb/tb_adder_bist.sv
// tb_adder_bist: directed sweeps against a fault-injectable adder model, scoreboarded on done.
module tb_adder_bist;
  localparam int W   = 4;
  localparam int S   = 2;
  localparam int EW  = W+1;
  localparam int LEN = (1 << (2*W+1)) * (S+1);
  typedef struct {
    logic [15:0] err;
    logic        fv;
    logic [2*W:0] ffv;
    logic        pass;
  } exp_t;
  logic clk = 0, rst = 0, start = 0;
  logic [1:0] fault = 2'd0;
  logic busy, done, pass, fail_valid;
  logic [15:0] err_count;
  logic [2*W:0] ffv, vec, vec_p;
  logic [EW-1:0] s;
  logic busy_p = 0, done_p = 0;
  int checks = 0, errors = 0, busy_len = 0, hold = 0;
  exp_t sb[$];
  adder_bist_if #(.WIDTH(W)) bus();
  adder_bist #(.WIDTH(W), .SETTLE(S)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_valid(fail_valid), .first_fail_vec(ffv)
  );
  always #5 clk = ~clk;
  assign s            = {1'b0, bus.dut_a} + {1'b0, bus.dut_b} + EW'(bus.dut_cin);
  assign bus.dut_sum  = fault == 2'd1 ? {s[W-1:1], 1'b0} : s[W-1:0];
  assign bus.dut_cout = fault == 2'd2 ? 1'b0 : s[W];
  assign vec          = {bus.dut_a, bus.dut_b, bus.dut_cin};
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic push(input logic [15:0] e, input logic f, input logic [2*W:0] v, input logic p);
    sb.push_back('{e, f, v, p});
  endtask
  task automatic pulse_start();
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic wait_done();
    int n = 0;
    while (!done && n < LEN + 100) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got done=0 expected done=1 within %0d cycles", LEN + 100);
    end
    @(negedge clk);
  endtask
  function automatic logic [63:0] outs();
    return {bus.dut_a, bus.dut_b, bus.dut_cin, busy, done, pass, err_count, fail_valid, ffv};
  endfunction
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy) begin
        if (!busy_p) begin
          busy_len = 0;
          hold = 1;
          chk("first_vec", vec, 0);
        end else if (vec == vec_p) begin
          hold++;
          chk("hold_max", hold <= S+1, 1);
        end else begin
          chk("vec_step", vec, vec_p + 1'b1);
          chk("window_len", hold, S+1);
          hold = 1;
        end
        busy_len++;
      end
      chk("busy_done_excl", busy && done, 0);
      if (done && !done_p) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard: got done expected none");
        end else begin
          e = sb.pop_front();
          chk("err_count", err_count, e.err);
          chk("fail_valid", fail_valid, e.fv);
          chk("first_fail_vec", ffv, e.ffv);
          chk("pass", pass, e.pass);
          chk("sweep_len", busy_len, LEN);
        end
      end
      busy_p = busy;
      done_p = done;
      vec_p  = vec;
    end
  end
  initial begin
    #1 rst = 1;
    #2 chk("reset_outputs", outs(), 0);
    @(negedge clk);
    rst = 0;
    push(16'd0, 1'b0, '0, 1'b1);
    pulse_start();
    wait_done();
    fault = 2'd1;
    push(16'd256, 1'b1, 9'h001, 1'b0);
    pulse_start();
    wait_done();
    fault = 2'd0;
    push(16'd0, 1'b0, '0, 1'b1);
    pulse_start();
    chk("restart_clear", {busy, done, pass, err_count, fail_valid, ffv}, {1'b1, 28'd0});
    wait_done();
    fault = 2'd2;
    push(16'd256, 1'b1, 9'h01F, 1'b0);
    pulse_start();
    wait_done();
    fault = 2'd0;
    push(16'd0, 1'b0, '0, 1'b1);
    pulse_start();
    repeat (8) @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (889) @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    wait_done();
    fault = 2'd1;
    pulse_start();
    repeat (699) @(negedge clk);
    #2 rst = 1;
    #1 chk("reset_mid_async", outs(), 0);
    @(negedge clk);
    chk("reset_mid_hold", outs(), 0);
    @(negedge clk);
    rst = 0;
    push(16'd256, 1'b1, 9'h001, 1'b0);
    pulse_start();
    wait_done();
    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
